dut: RTL and testbench
======================

DUT -- requirements
Module: dut

Interface
REQ-001 SHALL have a parameter-free interface; all message constants are fixed in RTL.
REQ-002 clk  input  1  rising-edge clock for all logic.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 enable  input  1  din holds a valid received byte this cycle.
REQ-005 start  input  1  one-cycle pulse: open session as initiator.
REQ-006 configure  input  1  one-cycle pulse: mark block configured.
REQ-007 din  input  8  received FIX byte (ASCII; ';' 0x3B is the field delimiter).
REQ-008 dout  output  8  transmitted FIX byte, registered.
REQ-009 valid  output  1  dout holds a transmitted byte this cycle.

Function
REQ-010 SHALL implement session states IDLE, LOGON_SENT, ACTIVE, plus a transmitter (TX_IDLE/TX_BUSY) independent of the receiver.
REQ-011 configure sampled high in IDLE SHALL set the internal configured flag; configure in other states SHALL be ignored.
REQ-012 start sampled high in IDLE with configured=1 SHALL launch a Logon (type 'A') transmission and enter LOGON_SENT; otherwise start SHALL be ignored.
REQ-013 Every outgoing message SHALL be exactly 27 bytes: "8=FIX.4.4;9=05;35=" T ";10=" C2 C1 C0 ";" (T = type byte), one byte per cycle, valid=1 on each, no gaps.
REQ-014 C2C1C0 SHALL be three ASCII decimal digits, zero-padded, equal to the sum mod 256 of the 20 bytes preceding "10=".
REQ-015 First outgoing byte SHALL appear with valid=1 in the cycle after the triggering event is sampled; valid SHALL be 0 and dout SHALL hold 0x00 whenever not transmitting.
REQ-016 Receiver SHALL process din only when enable=1, parsing fields as decimal tag digits, '=', value bytes, ';'.
REQ-017 Tag accumulation SHALL saturate at 999; non-digit bytes before '=' SHALL mark the field invalid; invalid fields SHALL be discarded.
REQ-018 Receiver SHALL record the first value byte of tag 35 as the message type; a ';' ending a tag-10 field SHALL complete the message; the incoming checksum SHALL NOT be validated.
REQ-019 On completion in LOGON_SENT: type 'A' -> ACTIVE, no output; type '5' -> IDLE, no output; others ignored.
REQ-020 On completion in ACTIVE: type '1' -> send Heartbeat (T='0'); type '5' -> send Logout (T='5'), then IDLE once sent; type '0' and others -> no output.
REQ-021 A reply triggered while the transmitter is busy SHALL be held in a one-deep pending slot and start the cycle after the current message ends; further triggers while pending is full SHALL be dropped.
REQ-022 A completed message lacking tag 35 SHALL be ignored; parser state SHALL clear after every completed message.
REQ-023 Receive and transmit SHALL operate concurrently; enable during transmission SHALL be processed normally.

Reset
REQ-024 reset=1 SHALL force IDLE, TX_IDLE, configured=0, pending empty, parser cleared, dout=0x00, valid=0 at the next clk edge, aborting any message mid-transmission.
REQ-025 reset SHALL take priority over start, configure and enable in the same cycle.

Configuration
REQ-026 With macro FIX_CHECKSUM_EN defined, C2C1C0 SHALL be computed per REQ-014.
REQ-027 Without FIX_CHECKSUM_EN, C2C1C0 SHALL be the constant "000" (0x30 0x30 0x30) and no checksum adder SHALL be synthesized.

Verification
REQ-028 reset, configure, start -> 27 valid bytes "8=FIX.4.4;9=05;35=A;10=146;" (0x38 0x3D 0x46 ... 0x31 0x34 0x36 0x3B), then valid=0.
REQ-029 start without prior configure -> valid stays 0, state IDLE.
REQ-030 After logon, feed "35=A;10=000;" then "35=1;10=000;" -> Heartbeat "...35=0;10=129;" starting the cycle after the last ';'.
REQ-031 In ACTIVE feed "35=5;10=000;" -> Logout "...35=5;10=134;", then a new start re-logs on.
REQ-032 Assert reset on byte 10 of the logon transmission -> valid=0, dout=0x00 next cycle; subsequent start ignored until configure.
REQ-033 Build without FIX_CHECKSUM_EN -> logon ends "10=000;".

Source files
------------

// File: rtl/dut.sv
// FIX 4.4 session endpoint: byte-serial receive parser, session FSM and 27-byte message transmitter.
// Optional macro FIX_CHECKSUM_EN: field 10 carries the real checksum; otherwise it is the constant "000".
module dut (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       start,
    input  logic       configure,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       valid
);
    // valid is a pure strobe with no ready: a byte is transferred on every cycle valid=1,
    // a message is 27 consecutive valid cycles, and dout is 0x00 whenever valid=0.

    typedef enum logic [1:0] {IDLE, LOGON_SENT, ACTIVE} session_e;
    typedef enum logic {TX_IDLE, TX_BUSY} tx_e;
    typedef struct packed {
        session_e session;
        tx_e      tx;
    } fsm_state_t;

    localparam logic [4:0] MSG_LEN  = 5'd27;
    localparam logic [4:0] SUM_LAST = 5'd19;
    localparam logic [7:0] SEMI     = 8'h3B;
    localparam logic [7:0] EQ       = 8'h3D;

    fsm_state_t st;
    session_e   session_nxt;
    tx_e        tx_nxt;
    logic       configured, cfg_nxt;

    logic       trig;
    logic [7:0] trig_type;

    logic [4:0] tx_idx, idx_nxt;
    logic [7:0] tx_type, type_nxt;
    logic       pend_v, pend_v_nxt;
    logic [7:0] pend_type, pend_type_nxt;
    logic       tx_done, load_pend, load_trig, store_trig;
    logic       emit;
    logic [4:0] emit_idx;
    logic [7:0] emit_type;
    logic [7:0] dout_nxt;
    logic [7:0] c2, c1, c0;

    logic       rx_in_val, first_val, tag_bad, have_type;
    logic [9:0] tag_q;
    logic [7:0] msg_type;
    logic       is_digit, rx_complete, rx_msg;
    logic [13:0] tag_calc;
    logic [9:0] tag_sat;

    function automatic logic [7:0] msg_byte(input logic [4:0] idx, input logic [7:0] t,
                                            input logic [7:0] d2, input logic [7:0] d1,
                                            input logic [7:0] d0);
        case (idx)
            5'd0:    msg_byte = "8";
            5'd1:    msg_byte = "=";
            5'd2:    msg_byte = "F";
            5'd3:    msg_byte = "I";
            5'd4:    msg_byte = "X";
            5'd5:    msg_byte = ".";
            5'd6:    msg_byte = "4";
            5'd7:    msg_byte = ".";
            5'd8:    msg_byte = "4";
            5'd9:    msg_byte = ";";
            5'd10:   msg_byte = "9";
            5'd11:   msg_byte = "=";
            5'd12:   msg_byte = "0";
            5'd13:   msg_byte = "5";
            5'd14:   msg_byte = ";";
            5'd15:   msg_byte = "3";
            5'd16:   msg_byte = "5";
            5'd17:   msg_byte = "=";
            5'd18:   msg_byte = t;
            5'd19:   msg_byte = ";";
            5'd20:   msg_byte = "1";
            5'd21:   msg_byte = "0";
            5'd22:   msg_byte = "=";
            5'd23:   msg_byte = d2;
            5'd24:   msg_byte = d1;
            5'd25:   msg_byte = d0;
            5'd26:   msg_byte = ";";
            default: msg_byte = 8'h00;
        endcase
    endfunction

    // ---------------- receive parser ----------------
    assign is_digit    = (din >= 8'h30) && (din <= 8'h39);
    assign tag_calc    = ({4'd0, tag_q} * 14'd10) + {10'd0, din[3:0]};
    assign tag_sat     = (tag_calc > 14'd999) ? 10'd999 : tag_calc[9:0];
    assign rx_complete = enable && rx_in_val && (din == SEMI) && !tag_bad && (tag_q == 10'd10);
    assign rx_msg      = rx_complete && have_type;

    always_ff @(posedge clk) begin
        if (reset || rx_complete) begin
            rx_in_val <= 1'b0;
            first_val <= 1'b0;
            tag_bad   <= 1'b0;
            tag_q     <= 10'd0;
            have_type <= 1'b0;
            msg_type  <= 8'h00;
        end else if (enable) begin
            if (!rx_in_val) begin
                if (din == EQ) begin
                    rx_in_val <= 1'b1;
                    first_val <= 1'b1;
                end else if (din == SEMI) begin
                    tag_q   <= 10'd0;
                    tag_bad <= 1'b0;
                end else if (is_digit) begin
                    tag_q <= tag_sat;
                end else begin
                    tag_bad <= 1'b1;
                end
            end else if (din == SEMI) begin
                rx_in_val <= 1'b0;
                first_val <= 1'b0;
                tag_q     <= 10'd0;
                tag_bad   <= 1'b0;
            end else begin
                first_val <= 1'b0;
                if (first_val && !tag_bad && (tag_q == 10'd35)) begin
                    msg_type  <= din;
                    have_type <= 1'b1;
                end
            end
        end
    end

    // ---------------- session FSM ----------------
    assign tx_done = (st.tx == TX_BUSY) && (tx_idx == MSG_LEN);

    always_comb begin
        session_nxt = st.session;
        cfg_nxt     = configured;
        trig        = 1'b0;
        trig_type   = 8'h00;
        case (st.session)
            IDLE: begin
                if (configure) cfg_nxt = 1'b1;
                if (start && configured) begin
                    trig        = 1'b1;
                    trig_type   = "A";
                    session_nxt = LOGON_SENT;
                end
            end
            LOGON_SENT: begin
                if (rx_msg && (msg_type == "A")) session_nxt = ACTIVE;
                else if (rx_msg && (msg_type == "5")) session_nxt = IDLE;
            end
            ACTIVE: begin
                if (rx_msg && (msg_type == "1")) begin
                    trig      = 1'b1;
                    trig_type = "0";
                end else if (rx_msg && (msg_type == "5")) begin
                    trig      = 1'b1;
                    trig_type = "5";
                end
                // Only Logout messages carry type '5', so its last byte closes the session.
                if (tx_done && (tx_type == "5")) session_nxt = IDLE;
            end
            default: session_nxt = IDLE;
        endcase
    end

    // ---------------- transmitter ----------------
    always_comb begin
        load_pend     = tx_done && pend_v;
        load_trig     = trig && ((st.tx == TX_IDLE) || (tx_done && !pend_v));
        store_trig    = trig && !load_trig && (!pend_v || load_pend);
        tx_nxt        = st.tx;
        idx_nxt       = tx_idx;
        type_nxt      = tx_type;
        pend_v_nxt    = pend_v;
        pend_type_nxt = pend_type;
        emit          = 1'b0;
        emit_idx      = tx_idx;
        emit_type     = tx_type;
        if (load_pend || load_trig) begin
            emit      = 1'b1;
            emit_idx  = 5'd0;
            emit_type = load_pend ? pend_type : trig_type;
            tx_nxt    = TX_BUSY;
            idx_nxt   = 5'd1;
            type_nxt  = emit_type;
            if (load_pend) pend_v_nxt = 1'b0;
        end else if ((st.tx == TX_BUSY) && !tx_done) begin
            emit    = 1'b1;
            idx_nxt = tx_idx + 5'd1;
        end else if (tx_done) begin
            tx_nxt  = TX_IDLE;
            idx_nxt = 5'd0;
        end
        if (store_trig) begin
            pend_v_nxt    = 1'b1;
            pend_type_nxt = trig_type;
        end
        dout_nxt = emit ? msg_byte(emit_idx, emit_type, c2, c1, c0) : 8'h00;
    end

`ifdef FIX_CHECKSUM_EN
    logic [7:0] chk_q;

    // Running sum of bytes 0..19; settled well before the digits go out at bytes 23..25.
    always_ff @(posedge clk) begin
        if (reset) chk_q <= 8'h00;
        else if (emit && (emit_idx == 5'd0)) chk_q <= dout_nxt;
        else if (emit && (emit_idx <= SUM_LAST)) chk_q <= chk_q + dout_nxt;
    end

    always_comb begin
        c2 = 8'h30 + (chk_q / 8'd100);
        c1 = 8'h30 + ((chk_q / 8'd10) % 8'd10);
        c0 = 8'h30 + (chk_q % 8'd10);
    end
`else
    always_comb begin
        c2 = 8'h30;
        c1 = 8'h30;
        c0 = 8'h30;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= '{session: IDLE, tx: TX_IDLE};
            configured <= 1'b0;
            tx_idx     <= 5'd0;
            tx_type    <= 8'h00;
            pend_v     <= 1'b0;
            pend_type  <= 8'h00;
            dout       <= 8'h00;
            valid      <= 1'b0;
        end else begin
            st         <= '{session: session_nxt, tx: tx_nxt};
            configured <= cfg_nxt;
            tx_idx     <= idx_nxt;
            tx_type    <= type_nxt;
            pend_v     <= pend_v_nxt;
            pend_type  <= pend_type_nxt;
            dout       <= dout_nxt;
            valid      <= emit;
        end
    end

endmodule

// File: tb/tb_dut.sv
// Bench for the FIX session endpoint: directed vector table, hand-written corner sequences,
// and a randomized run checked cycle by cycle against a queue-based message model.
module tb_dut;
    logic       clk = 1'b0;
    logic       reset, enable, start, configure;
    logic [7:0] din;
    logic [7:0] dout;
    logic       valid;

    dut u_dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .start     (start),
        .configure (configure),
        .din       (din),
        .dout      (dout),
        .valid     (valid)
    );

    always #5 clk = ~clk;

`ifdef FIX_CHECKSUM_EN
    localparam int CK_A = 146, CK_HB = 129, CK_LO = 134;
`else
    localparam int CK_A = 0, CK_HB = 0, CK_LO = 0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_LOGON, M_ACTIVE} m_sess_e;
    m_sess_e    m_sess = M_IDLE;
    bit         m_cfg, m_inflight, m_pend_v, m_has_type, m_vout;
    logic [7:0] m_cur_t, m_pend_t, m_type, m_out;
    logic [7:0] exp_q[$];
    logic [7:0] m_field[$];

    logic [7:0] cap[$];
    int         first_step, last_step;
    logic [7:0] stim_q[$];

    task automatic push_msg(input logic [7:0] t);
        string hdr = "8=FIX.4.4;9=05;35=";
        int    sum = 0;
        int    ck;
        for (int i = 0; i < hdr.len(); i++) begin
            exp_q.push_back(hdr[i]);
            sum += hdr[i];
        end
        exp_q.push_back(t);
        exp_q.push_back(8'h3B);
        sum += t + 8'h3B;
`ifdef FIX_CHECKSUM_EN
        ck = sum % 256;
`else
        ck = 0;
`endif
        exp_q.push_back("1");
        exp_q.push_back("0");
        exp_q.push_back("=");
        exp_q.push_back(8'(48 + ck / 100));
        exp_q.push_back(8'(48 + (ck / 10) % 10));
        exp_q.push_back(8'(48 + ck % 10));
        exp_q.push_back(8'h3B);
    endtask

    // Interpret one whole field (bytes before its ';').
    task automatic parse_field(output bit complete);
        int eq_pos = -1;
        int tag    = 0;
        bit ok     = 1;
        complete = 0;
        for (int i = 0; i < m_field.size(); i++)
            if (eq_pos < 0 && m_field[i] == 8'h3D) eq_pos = i;
        if (eq_pos < 0) ok = 0;
        for (int i = 0; i < eq_pos; i++) begin
            if (m_field[i] < 8'h30 || m_field[i] > 8'h39) ok = 0;
            else begin
                tag = tag * 10 + (int'(m_field[i]) - 48);
                if (tag > 999) tag = 999;
            end
        end
        if (ok && tag == 35 && m_field.size() > eq_pos + 1) begin
            m_type     = m_field[eq_pos + 1];
            m_has_type = 1;
        end
        if (ok && tag == 10) complete = 1;
        m_field.delete();
    endtask

    task automatic model_step();
        bit         trig = 0;
        logic [7:0] trig_t = 8'h00;
        bit         done_msg = 0;
        bit         fin;
        bit         old_cfg;
        m_sess_e    ns;
        if (reset) begin
            m_sess = M_IDLE; m_cfg = 0; m_inflight = 0; m_pend_v = 0; m_has_type = 0;
            exp_q.delete(); m_field.delete();
            m_vout = 0; m_out = 8'h00;
            return;
        end
        if (enable && din == 8'h3B) parse_field(done_msg);
        else if (enable) m_field.push_back(din);
        ns      = m_sess;
        old_cfg = m_cfg;
        fin     = m_inflight && exp_q.size() == 0;
        case (m_sess)
            M_IDLE: begin
                if (configure) m_cfg = 1;
                if (start && old_cfg) begin trig = 1; trig_t = "A"; ns = M_LOGON; end
            end
            M_LOGON: if (done_msg && m_has_type) begin
                if (m_type == "A") ns = M_ACTIVE;
                else if (m_type == "5") ns = M_IDLE;
            end
            default: begin
                if (done_msg && m_has_type && m_type == "1") begin trig = 1; trig_t = "0"; end
                if (done_msg && m_has_type && m_type == "5") begin trig = 1; trig_t = "5"; end
                if (fin && m_cur_t == "5") ns = M_IDLE;
            end
        endcase
        if (done_msg) m_has_type = 0;
        m_sess = ns;
        if (exp_q.size() == 0) begin
            if (m_pend_v) begin
                push_msg(m_pend_t); m_cur_t = m_pend_t; m_pend_v = 0; m_inflight = 1;
            end else if (trig) begin
                push_msg(trig_t); m_cur_t = trig_t; trig = 0; m_inflight = 1;
            end else m_inflight = 0;
        end
        if (trig && !m_pend_v) begin m_pend_v = 1; m_pend_t = trig_t; end
        if (exp_q.size() > 0) begin m_out = exp_q.pop_front(); m_vout = 1; end
        else begin m_out = 8'h00; m_vout = 0; end
    endtask

    // ---------------- driver / checker ----------------
    task automatic check_out();
        checks++;
        if (valid !== m_vout || dout !== m_out) begin
            errors++;
            $display("FAIL out@%0d: valid=%b dout=%h want valid=%b dout=%h", cyc, valid, dout, m_vout, m_out);
        end
        if (valid === 1'b1) begin
            if (cap.size() == 0) first_step = cyc;
            cap.push_back(dout);
            last_step = cyc;
        end
    endtask

    task automatic step(input bit r, input bit s, input bit c, input bit e, input logic [7:0] d);
        reset = r; start = s; configure = c; enable = e; din = d;
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        check_out();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 8'($urandom));
    endtask

    task automatic feed(input string s, output int last);
        for (int i = 0; i < s.len(); i++) step(0, 0, 0, 1, s[i]);
        last = cyc;
    endtask

    task automatic clear_cap();
        cap.delete();
        first_step = -1;
        last_step  = -1;
    endtask

    function automatic string cap_str();
        string s = "";
        foreach (cap[i]) s = $sformatf("%s%c", s, cap[i]);
        return s;
    endfunction

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic check_msg(input string name, input string exp);
        bit ok;
        checks++;
        ok = (cap.size() == exp.len());
        if (ok) for (int i = 0; i < exp.len(); i++) if (cap[i] !== exp[i]) ok = 0;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d bytes \"%s\" want \"%s\"", name, cap.size(), cap_str(), exp);
        end
    endtask

    function automatic string fix_msg(input logic [7:0] t, input int ck);
        return $sformatf("8=FIX.4.4;9=05;35=%c;10=%03d;", t, ck);
    endfunction

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) stim_q.push_back(s[i]);
    endtask

    task automatic gen_msg();
        int         nf = $urandom_range(0, 2);
        logic [7:0] t;
        for (int i = 0; i < nf; i++)
            case ($urandom_range(0, 5))
                0:       push_str("49=ABC;");
                1:       push_str("3X5=1;");
                2:       push_str("10035=1;");
                3:       push_str("351;");
                4:       push_str("35=;");
                default: push_str("9999999010=0;");
            endcase
        if ($urandom_range(0, 9) != 0) begin
            case ($urandom_range(0, 9))
                0, 1, 2: t = "A";
                6:       t = "5";
                7:       t = "0";
                8:       t = "X";
                default: t = "1";
            endcase
            push_str(($urandom_range(0, 3) == 0) ? "0035=" : "35=");
            stim_q.push_back(t);
            if ($urandom_range(0, 3) == 0) stim_q.push_back("Z");
            stim_q.push_back(8'h3B);
        end
        push_str(($urandom_range(0, 1) == 0) ? "10=000;" : "10=123;");
    endtask

    typedef struct {
        logic [7:0] rx_t;
        bit         reply;
        logic [7:0] rep_t;
        int         cks;
    } vec_t;
    vec_t vecs[6];

    initial begin
        int last;
        int l1;
        vecs[0] = '{rx_t: "1", reply: 1'b1, rep_t: "0", cks: CK_HB};
        vecs[1] = '{rx_t: "0", reply: 1'b0, rep_t: "0", cks: 0};
        vecs[2] = '{rx_t: "X", reply: 1'b0, rep_t: "0", cks: 0};
        vecs[3] = '{rx_t: "A", reply: 1'b0, rep_t: "0", cks: 0};
        vecs[4] = '{rx_t: "1", reply: 1'b1, rep_t: "0", cks: CK_HB};
        vecs[5] = '{rx_t: "5", reply: 1'b1, rep_t: "5", cks: CK_LO};

        reset = 1'b1; start = 1'b0; configure = 1'b0; enable = 1'b0; din = 8'h00;
        clear_cap();
        step(1, 0, 0, 0, 8'h00);
        step(1, 1, 1, 1, 8'h3B);
        check_int("reset_valid", valid, 0);
        check_int("reset_dout", dout, 0);

        // start without configure is ignored
        step(0, 1, 0, 0, 8'h00);
        idle(30);
        check_int("start_unconfigured", cap.size(), 0);

        step(0, 0, 1, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        last = cyc;
        idle(32);
        check_msg("logon", fix_msg("A", CK_A));
        check_int("logon_latency", first_step, last);

        clear_cap();
        feed("35=A;10=000;", last);
        idle(5);
        check_int("logon_ack_silent", cap.size(), 0);

        foreach (vecs[i]) begin
            clear_cap();
            feed($sformatf("35=%c;10=000;", vecs[i].rx_t), last);
            idle(34);
            if (vecs[i].reply) begin
                check_msg($sformatf("vec%0d_msg", i), fix_msg(vecs[i].rep_t, vecs[i].cks));
                check_int($sformatf("vec%0d_latency", i), first_step, last);
            end else begin
                check_int($sformatf("vec%0d_silent", i), cap.size(), 0);
            end
        end

        // after logout, a fresh start re-logs on
        clear_cap();
        step(0, 1, 0, 0, 8'h00);
        idle(32);
        check_msg("relogon", fix_msg("A", CK_A));
        feed("35=A;10=000;", last);

        // back-to-back requests: one held pending, the third dropped
        clear_cap();
        feed("35=1;10=000;", l1);
        feed("35=1;10=000;", last);
        feed("35=1;10=000;", last);
        idle(60);
        check_int("pend_bytes", cap.size(), 54);
        check_int("pend_start", first_step, l1);
        check_int("pend_span", last_step - first_step, 53);

        feed("35=5;10=000;", last);
        idle(35);

        // reset while byte 10 of a logon is on the wire
        clear_cap();
        step(0, 1, 0, 0, 8'h00);
        idle(9);
        step(1, 0, 0, 0, 8'h00);
        check_int("abort_valid", valid, 0);
        check_int("abort_dout", dout, 0);
        check_int("abort_bytes", cap.size(), 10);
        idle(3);
        clear_cap();
        step(0, 1, 0, 0, 8'h00);
        idle(30);
        check_int("start_after_reset", cap.size(), 0);
        step(0, 0, 1, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        idle(30);
        check_msg("logon_after_reset", fix_msg("A", CK_A));

        // randomized traffic against the model
        for (int n = 0; n < 5000; n++) begin
            bit         r, s, c, e;
            logic [7:0] d;
            if (stim_q.size() == 0) gen_msg();
            r = ($urandom_range(0, 1499) == 0);
            s = ($urandom_range(0, 39) == 0);
            c = ($urandom_range(0, 59) == 0);
            e = ($urandom_range(0, 3) != 0);
            d = e ? stim_q.pop_front() : 8'($urandom);
            step(r, s, c, e, d);
        end
        idle(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
